// File: rtl/wvb_readout_arbiter.sv
// wvb_readout_arbiter: round-robin readout of P_N_CHAN waveform buffers.
// A channel is eligible when it is enabled and its header FIFO is non-empty.
// For each granted channel the block emits one header beat followed by the
// waveform words. A word's MSB ends the waveform, and the P_MAX_WORDS-th word
// also ends it.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   chan_en           per-channel readout enable
//   hdr_empty         per-channel header FIFO empty
//   hdr_data_in       FWFT headers, channel i at [i*P_HDR_WIDTH +: P_HDR_WIDTH]
//   wvb_data_in       waveform words, channel i at [i*P_DATA_WIDTH +: P_DATA_WIDTH]
//   hdr_rdreq         header pop pulse (first HDR cycle)
//   wvb_rdreq         word read pulse (1-cycle buffer latency)
//   wvb_rddone        waveform release pulse
//   out_valid/ready   output handshake
//   out_is_hdr        current beat is a header
//   out_hdr/out_data  latched header / word
//   out_last          final word of the waveform
//   out_chan          source channel
//   busy              readout in progress
//   len_err           sticky word-limit violation, cleared by len_err_clr
module wvb_readout_arbiter #(
  parameter int unsigned P_N_CHAN     = 8,
  parameter int unsigned P_CHAN_WIDTH = 3,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_MAX_WORDS  = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [P_N_CHAN-1:0]              chan_en,
  input  logic [P_N_CHAN-1:0]              hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data_in,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data_in,
  output logic [P_N_CHAN-1:0]              hdr_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_rddone,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_is_hdr,
  output logic [P_HDR_WIDTH-1:0]           out_hdr,
  output logic [P_DATA_WIDTH-1:0]          out_data,
  output logic                             out_last,
  output logic [P_CHAN_WIDTH-1:0]          out_chan,
  output logic                             busy,
  output logic                             len_err,
  input  logic                             len_err_clr
);

  localparam int unsigned CNT_W = $clog2(P_MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [P_N_CHAN-1:0]       hdr_rdreq_q, hdr_rdreq_d;
  logic [P_N_CHAN-1:0]       wvb_rdreq_q, wvb_rdreq_d;
  logic [P_N_CHAN-1:0]       wvb_rddone_q, wvb_rddone_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_is_hdr_q, out_is_hdr_d;
  logic [P_HDR_WIDTH-1:0]    out_hdr_q, out_hdr_d;
  logic [P_DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic [P_CHAN_WIDTH-1:0]   out_chan_q, out_chan_d;
  logic                      busy_q, busy_d;
  logic                      len_err_q, len_err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [P_CHAN_WIDTH-1:0]   last_served_q, last_served_d;

  logic [P_N_CHAN-1:0]       eligible;
  logic                      grant_vld;
  logic [P_CHAN_WIDTH-1:0]   grant_idx;
  logic [P_DATA_WIDTH-1:0]   sel_word;
  logic                      forced_last;

  assign eligible = chan_en & ~hdr_empty;
  assign sel_word = wvb_data_in[int'(out_chan_q)*int'(P_DATA_WIDTH) +: P_DATA_WIDTH];

  // Round-robin pick: scan from last_served+1 upward; descending loop so the nearest wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = int'(P_N_CHAN); k >= 1; k--) begin
      idx = (int'(last_served_q) + k) % int'(P_N_CHAN);
      if (eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = P_CHAN_WIDTH'(idx);
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    hdr_rdreq_d   = '0;
    wvb_rdreq_d   = '0;
    wvb_rddone_d  = '0;
    out_valid_d   = out_valid_q;
    out_is_hdr_d  = out_is_hdr_q;
    out_hdr_d     = out_hdr_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_chan_d    = out_chan_q;
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    forced_last   = 1'b0;
    // Clear first so a violation recorded below in the same cycle overrides it.
    len_err_d     = len_err_q & ~len_err_clr;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          out_hdr_d              = hdr_data_in[int'(grant_idx)*int'(P_HDR_WIDTH) +: P_HDR_WIDTH];
          out_chan_d             = grant_idx;
          out_is_hdr_d           = 1'b1;
          out_valid_d            = 1'b1;
          out_last_d             = 1'b0;
          busy_d                 = 1'b1;
          hdr_rdreq_d[grant_idx] = 1'b1;
          state_d                = S_HDR;
        end
      end
      S_HDR: begin
        if (out_ready) begin
          out_valid_d             = 1'b0;
          wvb_rdreq_d[out_chan_q] = 1'b1;
          state_d                 = S_RD;
        end
      end
      S_RD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d        = cnt_q + CNT_W'(1);
        forced_last  = (cnt_d == CNT_W'(P_MAX_WORDS));
        out_data_d   = sel_word;
        out_is_hdr_d = 1'b0;
        out_valid_d  = 1'b1;
        out_last_d   = sel_word[P_DATA_WIDTH-1] | forced_last;
        // A waveform that ends exactly at the limit is legal; only a missing flag is an error.
        if (forced_last && !sel_word[P_DATA_WIDTH-1]) begin
          len_err_d = 1'b1;
        end
        state_d = S_DATA;
      end
      S_DATA: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            wvb_rddone_d[out_chan_q] = 1'b1;
            state_d                  = S_DONE;
          end else begin
            wvb_rdreq_d[out_chan_q] = 1'b1;
            state_d                 = S_RD;
          end
        end
      end
      S_DONE: begin
        last_served_d = out_chan_q;
        busy_d        = 1'b0;
        cnt_d         = '0;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hdr_rdreq_q   <= '0;
      wvb_rdreq_q   <= '0;
      wvb_rddone_q  <= '0;
      out_valid_q   <= 1'b0;
      out_is_hdr_q  <= 1'b0;
      out_hdr_q     <= '0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_chan_q    <= '0;
      busy_q        <= 1'b0;
      len_err_q     <= 1'b0;
      cnt_q         <= '0;
      last_served_q <= P_CHAN_WIDTH'(P_N_CHAN - 1);
    end else begin
      state_q       <= state_d;
      hdr_rdreq_q   <= hdr_rdreq_d;
      wvb_rdreq_q   <= wvb_rdreq_d;
      wvb_rddone_q  <= wvb_rddone_d;
      out_valid_q   <= out_valid_d;
      out_is_hdr_q  <= out_is_hdr_d;
      out_hdr_q     <= out_hdr_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_chan_q    <= out_chan_d;
      busy_q        <= busy_d;
      len_err_q     <= len_err_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
    end
  end

  assign hdr_rdreq  = hdr_rdreq_q;
  assign wvb_rdreq  = wvb_rdreq_q;
  assign wvb_rddone = wvb_rddone_q;
  assign out_valid  = out_valid_q;
  assign out_is_hdr = out_is_hdr_q;
  assign out_hdr    = out_hdr_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_chan   = out_chan_q;
  assign busy       = busy_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// Self-checking bench for wvb_readout_arbiter (built with a 4-word limit).
module tb_wvb_readout_arbiter;

  localparam int unsigned NCH  = 8;
  localparam int unsigned CW   = 3;
  localparam int unsigned DW   = 22;
  localparam int unsigned HW   = 80;
  localparam int unsigned MAXW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      chan_en;
  logic [NCH-1:0]      hdr_empty;
  logic [NCH*HW-1:0]   hdr_data_in;
  logic [NCH*DW-1:0]   wvb_data_in;
  logic [NCH-1:0]      hdr_rdreq;
  logic [NCH-1:0]      wvb_rdreq;
  logic [NCH-1:0]      wvb_rddone;
  logic                out_valid;
  logic                out_ready;
  logic                out_is_hdr;
  logic [HW-1:0]       out_hdr;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic [CW-1:0]       out_chan;
  logic                busy;
  logic                len_err;
  logic                len_err_clr;

  always #5 clk = ~clk;

  wvb_readout_arbiter #(
    .P_N_CHAN(NCH), .P_CHAN_WIDTH(CW), .P_DATA_WIDTH(DW),
    .P_HDR_WIDTH(HW), .P_MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst(rst), .chan_en(chan_en), .hdr_empty(hdr_empty),
    .hdr_data_in(hdr_data_in), .wvb_data_in(wvb_data_in),
    .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_hdr(out_is_hdr),
    .out_hdr(out_hdr), .out_data(out_data), .out_last(out_last),
    .out_chan(out_chan), .busy(busy), .len_err(len_err), .len_err_clr(len_err_clr)
  );

  int checks = 0;
  int errors = 0;
  int hdr_avail[NCH];
  int pops[NCH];
  int wlen[NCH];
  int rddone_cnt[NCH];
  int ptr[NCH];
  int grants[$];

  // Waveform k of channel ch; wlen==0 means the flag never appears.
  function automatic logic [DW-1:0] wword(input int ch, input int k);
    logic flag;
    flag = (wlen[ch] != 0) && (k == wlen[ch] - 1);
    return {flag, 21'(ch * 256 + k)};
  endfunction

  function automatic logic [HW-1:0] hword(input int ch, input int n);
    return {16'(16'hA000 + ch), 64'(n)};
  endfunction

  // Buffer model: word appears one cycle after its read pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) ptr[i] <= 0;
      wvb_data_in <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wvb_rddone[i]) begin
          ptr[i] <= 0;
        end else if (wvb_rdreq[i]) begin
          wvb_data_in[i*DW +: DW] <= wword(i, ptr[i]);
          ptr[i] <= ptr[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NCH; i++) begin
      hdr_empty[i] = (hdr_avail[i] == 0);
      hdr_data_in[i*HW +: HW] = hword(i, pops[i]);
    end
  endtask

  function automatic logic [159:0] all_out();
    return 160'({hdr_rdreq, wvb_rdreq, wvb_rddone, out_valid, out_is_hdr, out_hdr,
                 out_data, out_last, out_chan, busy, len_err});
  endfunction

  // Advance one cycle and sample just after the edge; also tracks pops and pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("pulse_onehot",
        {157'd0, ($countones(hdr_rdreq) > 1), ($countones(wvb_rdreq) > 1), ($countones(wvb_rddone) > 1)},
        160'd0);
    for (int i = 0; i < NCH; i++) begin
      if (hdr_rdreq[i]) begin
        grants.push_back(i);
        pops[i]++;
        if (hdr_avail[i] > 0) hdr_avail[i]--;
      end
      if (wvb_rddone[i]) rddone_cnt[i]++;
    end
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chan_en = '0;
    out_ready = 1'b1;
    len_err_clr = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      hdr_avail[i] = 0; pops[i] = 0; wlen[i] = 0; rddone_cnt[i] = 0;
    end
    refresh();
    tick();
    tick();
    chk("reset_outputs", all_out(), 160'd0);
    grants.delete();
    rst = 1'b0;
  endtask

  // Run one waveform of ch to completion with out_ready high, checking each beat.
  task automatic run_wave(input int ch, input int nw, input int errw);
    int k;
    int dn0;
    logic [HW-1:0] eh;
    bit hseen;
    k = 0; dn0 = rddone_cnt[ch]; eh = hword(ch, pops[ch]); hseen = 0;
    for (int n = 0; n < 400 && k < nw; n++) begin
      tick();
      if (out_valid && out_is_hdr && !hseen) begin
        chk("hdr_value", 160'(out_hdr), 160'(eh));
        chk("hdr_chan", 160'(out_chan), 160'(ch));
        hseen = 1;
      end
      if (out_valid && !out_is_hdr) begin
        chk("word_data", 160'(out_data), 160'(wword(ch, k)));
        chk("word_last", 160'(out_last), 160'(k == nw - 1));
        chk("word_chan", 160'(out_chan), 160'(ch));
        chk("word_len_err", 160'(len_err), 160'(k == errw));
        k++;
      end
    end
    chk("word_count", 160'(k), 160'(nw));
    for (int n = 0; n < 50 && busy; n++) tick();
    chk("busy_drop", 160'(busy), 160'd0);
    chk("rddone_once", 160'(rddone_cnt[ch] - dn0), 160'd1);
  endtask

  typedef struct {
    logic           v, h, l, b;
    logic [NCH-1:0] hr, wr, dn;
    logic           dchk;
    logic [DW-1:0]  d;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic h, input logic l, input logic b,
                              input logic [7:0] hr, input logic [7:0] wr, input logic [7:0] dn,
                              input logic dchk, input logic [DW-1:0] d);
    vec_t r;
    r.v = v; r.h = h; r.l = l; r.b = b; r.hr = hr; r.wr = wr; r.dn = dn; r.dchk = dchk; r.d = d;
    return r;
  endfunction

  vec_t tbl[12];
  int   exp_g[6];
  logic [DW-1:0] held;
  int   k;

  initial begin
    // Cycle-by-cycle readout of a lone 3-word waveform on ch2.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 8'h00, 8'h00, 1'b0, 22'h0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h04, 8'h00, 1'b0, 22'h0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 22'h0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 22'h000200);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 8'h00, 1'b0, 22'h0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 22'h0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 22'h000201);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 8'h00, 1'b0, 22'h0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 22'h0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 22'h200202);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h04, 1'b0, 22'h0);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 22'h0);
    exp_g = '{0, 3, 7, 0, 3, 7};

    do_reset();
    chan_en = 8'h04; hdr_avail[2] = 1; wlen[2] = 3; refresh();
    for (int r = 0; r < 12; r++) begin
      tick();
      chk($sformatf("t%0d_valid", r), 160'(out_valid), 160'(tbl[r].v));
      chk($sformatf("t%0d_is_hdr", r), 160'(out_is_hdr), 160'(tbl[r].h));
      chk($sformatf("t%0d_last", r), 160'(out_last), 160'(tbl[r].l));
      chk($sformatf("t%0d_busy", r), 160'(busy), 160'(tbl[r].b));
      chk($sformatf("t%0d_hdr_rdreq", r), 160'(hdr_rdreq), 160'(tbl[r].hr));
      chk($sformatf("t%0d_wvb_rdreq", r), 160'(wvb_rdreq), 160'(tbl[r].wr));
      chk($sformatf("t%0d_rddone", r), 160'(wvb_rddone), 160'(tbl[r].dn));
      if (r == 0) chk("t0_hdr", 160'(out_hdr), 160'(hword(2, 0)));
      if (tbl[r].dchk) begin
        chk($sformatf("t%0d_data", r), 160'(out_data), 160'(tbl[r].d));
        chk($sformatf("t%0d_chan", r), 160'(out_chan), 160'd2);
      end
    end
    tick();
    chk("t_idle_after", 160'({busy, out_valid, hdr_rdreq}), 160'd0);

    // Round robin among 0, 3, 7.
    do_reset();
    chan_en = 8'h89;
    hdr_avail[0] = 10; hdr_avail[3] = 10; hdr_avail[7] = 10;
    wlen[0] = 1; wlen[3] = 1; wlen[7] = 1; refresh();
    for (int n = 0; n < 300 && grants.size() < 6; n++) tick();
    chk("rr_grant_count", 160'(grants.size() >= 6), 160'd1);
    for (int g = 0; g < 6 && g < grants.size(); g++)
      chk($sformatf("rr_grant%0d", g), 160'(grants[g]), 160'(exp_g[g]));

    // Backpressure in DATA for 10 cycles.
    do_reset();
    chan_en = 8'h10; hdr_avail[4] = 1; wlen[4] = 3; refresh();
    for (int n = 0; n < 100 && !(out_valid && !out_is_hdr); n++) tick();
    chk("bp_first_word", 160'(out_data), 160'(wword(4, 0)));
    held = out_data;
    out_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("bp_hold_valid", 160'(out_valid), 160'd1);
      chk("bp_hold_data", 160'(out_data), 160'(held));
      chk("bp_no_rdreq", 160'(wvb_rdreq), 160'd0);
    end
    out_ready = 1'b1;
    k = 1;
    for (int n = 0; n < 100 && k < 3; n++) begin
      tick();
      if (out_valid && !out_is_hdr) begin
        chk("bp_resume_data", 160'(out_data), 160'(wword(4, k)));
        chk("bp_resume_last", 160'(out_last), 160'(k == 2));
        k++;
      end
    end
    chk("bp_resume_count", 160'(k), 160'd3);

    // Word limit without a flag, legal exact-limit waveform, then set-over-clear.
    do_reset();
    chan_en = 8'h02; hdr_avail[1] = 1; wlen[1] = 0; refresh();
    run_wave(1, 4, 3);
    repeat (5) tick();
    chk("len_err_sticky", 160'(len_err), 160'd1);
    len_err_clr = 1'b1;
    tick();
    len_err_clr = 1'b0;
    chk("len_err_cleared", 160'(len_err), 160'd0);
    chan_en = 8'h40; hdr_avail[6] = 1; wlen[6] = 4; refresh();
    run_wave(6, 4, -1);
    chk("len_err_exact_limit", 160'(len_err), 160'd0);
    chan_en = 8'h02; hdr_avail[1] = 1; refresh();
    len_err_clr = 1'b1;
    run_wave(1, 4, 3);
    chk("len_err_clr_after_set", 160'(len_err), 160'd0);
    len_err_clr = 1'b0;

    // Disabled channel never granted until enabled.
    do_reset();
    chan_en = 8'hDF; hdr_avail[5] = 1; wlen[5] = 1; refresh();
    repeat (20) tick();
    chk("ch5_disabled_busy", 160'(busy), 160'd0);
    chk("ch5_disabled_grants", 160'(grants.size()), 160'd0);
    chan_en = 8'hFF;
    run_wave(5, 1, -1);

    // Reset in WAIT abandons the waveform; channel 0 wins afterwards.
    do_reset();
    chan_en = 8'h08; hdr_avail[3] = 1; wlen[3] = 3; refresh();
    for (int n = 0; n < 100 && wvb_rdreq == '0; n++) tick();
    chk("rst_reach_rd", 160'(wvb_rdreq), 160'h08);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", all_out(), 160'd0);
    tick();
    chk("rst_mid_hold", all_out(), 160'd0);
    chk("rst_no_rddone", 160'(rddone_cnt[3]), 160'd0);
    chan_en = 8'h09; hdr_avail[0] = 1; wlen[0] = 1; hdr_avail[3] = 1; refresh();
    grants.delete();
    rst = 1'b0;
    for (int n = 0; n < 50 && grants.size() < 1; n++) tick();
    chk("rst_first_grant_seen", 160'(grants.size() >= 1), 160'd1);
    if (grants.size() >= 1) chk("rst_first_grant_ch0", 160'(grants[0]), 160'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
